ram_burst_reader: RTL and testbench

Read-side burst engine for the 64x8 single-port RAM. On a start command it issues sequential read addresses from a base, absorbs the RAM's one-cycle registered read latency, and delivers the words as a valid/ready stream with full backpressure. It sits between the RAM's `read_addr`/`q` pins and any stream consumer (UART TX, checksum, DMA-out).

---
 rtl/ram_burst_reader.sv | 158 +++++++++++++++
 tb/tb_ram_burst_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// ram_burst_reader
// Read-side burst engine for a single-port RAM with a one-cycle registered
// read. A start command loads a base address and a word count; the engine
// then issues sequential addresses, catches each word one cycle later in a
// 2-entry FIFO and presents it as a valid/ready stream with full backpressure.
//
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   start             : burst request, only honoured while idle
//   base_addr, len    : first address and word count (0..2^ADDR_WIDTH)
//   read_addr         : registered address to the RAM
//   ram_q             : RAM read data, valid the cycle after the address
//   out_data/valid    : stream data and valid (FIFO head / FIFO not empty)
//   out_ready         : consumer ready
//   out_last          : final beat marker (only with RAM_BURST_READER_LAST_EN)
//   busy              : burst in progress
//   done              : one-cycle pulse after the last beat is accepted
//
// Build option: define RAM_BURST_READER_LAST_EN to generate out_last; without
// it out_last is tied low.
module ram_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [CW-1:0]          issue_rem_q, issue_rem_d;
    logic [CW-1:0]          deliver_rem_q, deliver_rem_d;
    logic                   inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0]  fifo_q [2];
    logic [DATA_WIDTH-1:0]  fifo_d [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;
    logic                   done_q, done_d;

    logic       accept, issue, push, pop, last_pop;
    logic [2:0] occ;

    assign accept   = (state_q == IDLE) && start;
    assign push     = inflight_q;
    assign pop      = (count_q != 2'd0) && out_ready;
    // Words that will occupy the FIFO after this edge, not counting a new
    // issue. Keeping this below 2 leaves room for the word an issue brings.
    assign occ      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue    = (state_q == READ) && (issue_rem_q != '0) && (occ < 3'd2);
    assign last_pop = (state_q == DRAIN) && pop && (deliver_rem_q == CW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && len != '0)                    state_d = READ;
            READ:    if (issue && issue_rem_q == CW'(1))        state_d = DRAIN;
            DRAIN:   if (last_pop)                              state_d = IDLE;
            default:                                            state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state_q != IDLE);
        out_valid = (count_q != 2'd0);
        out_data  = fifo_q[rd_ptr_q];
        done      = done_q;
`ifdef RAM_BURST_READER_LAST_EN
        out_last  = out_valid && (deliver_rem_q == CW'(1));
`else
        out_last  = 1'b0;
`endif
    end

    assign read_addr = addr_q;

    // Datapath next-state
    always_comb begin
        addr_d        = addr_q;
        issue_rem_d   = issue_rem_q;
        deliver_rem_d = deliver_rem_q;
        inflight_d    = issue;
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q + {1'b0, push} - {1'b0, pop};
        done_d        = last_pop;

        if (accept) begin
            if (len != '0) begin
                addr_d        = base_addr;
                issue_rem_d   = len;
                deliver_rem_d = len;
            end else begin
                done_d = 1'b1;  // empty burst completes immediately
            end
        end
        if (issue) begin
            addr_d      = addr_q + ADDR_WIDTH'(1);  // wraps silently
            issue_rem_d = issue_rem_q - CW'(1);
        end
        if (push) begin
            fifo_d[wr_ptr_q] = ram_q;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d      = ~rd_ptr_q;
            deliver_rem_d = deliver_rem_q - CW'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q        <= '0;
            issue_rem_q   <= '0;
            deliver_rem_q <= '0;
            inflight_q    <= 1'b0;
            fifo_q        <= '{default: '0};
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            done_q        <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            issue_rem_q   <= issue_rem_d;
            deliver_rem_q <= deliver_rem_d;
            inflight_q    <= inflight_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            done_q        <= done_d;
        end
    end
endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a 64x8 registered-read RAM model.
module tb_ram_burst_reader;
`ifdef RAM_BURST_READER_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic       clk, rst, start, out_ready;
    logic [5:0] base_addr, read_addr;
    logic [6:0] len;
    logic [7:0] ram_q, out_data;
    logic       out_valid, out_last, busy, done;

    logic [7:0] mem [0:63];

    int errors = 0;
    int checks = 0;

    // per-cycle trace captured at the falling edge
    logic       tr_v [0:127];
    logic       tr_r [0:127];
    logic       tr_l [0:127];
    logic       tr_done [0:127];
    logic [7:0] tr_d [0:127];
    logic [5:0] tr_a [0:127];
    int         tr_n;

    ram_burst_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .read_addr(read_addr), .ram_q(ram_q), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) ram_q <= mem[read_addr];

    task automatic do_start(input logic [5:0] b, input logic [6:0] l);
        @(negedge clk);
        start = 1'b1; base_addr = b; len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records outputs each cycle until done is seen or maxc cycles pass.
    task automatic capture(input logic [3:0] pat, input int maxc);
        tr_n = 0;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            out_ready     = pat[c % 4];
            tr_v[tr_n]    = out_valid;
            tr_r[tr_n]    = out_ready;
            tr_l[tr_n]    = out_last;
            tr_done[tr_n] = done;
            tr_d[tr_n]    = out_data;
            tr_a[tr_n]    = read_addr;
            tr_n++;
            if (done) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i + 16);
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_last, busy, done} !== 4'b0000 || read_addr !== 6'd0 || out_data !== 8'd0) begin
            errors++;
            $display("FAIL reset: v=%b l=%b busy=%b done=%b addr=%0d data=%h want all 0",
                     out_valid, out_last, busy, done, read_addr, out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        do_start(6'd5, 7'd4);
        checks++;
        if (busy !== 1'b1 || read_addr !== 6'd5 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_e0: busy=%b addr=%0d v=%b want 1 5 0", busy, read_addr, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || read_addr !== 6'd6) begin
            errors++;
            $display("FAIL basic_e1: v=%b addr=%0d want 0 6", out_valid, read_addr);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'h15 + b) || done !== 1'b0 ||
                out_last !== (LAST_EN && b == 3)) begin
                errors++;
                $display("FAIL basic_beat%0d: v=%b data=%h last=%b done=%b want 1 %h %b 0",
                         b, out_valid, out_data, out_last, done, 8'(8'h15 + b), LAST_EN && b == 3);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b v=%b want 1 0 0", done, busy, out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: done=%b want 0", done);
        end
    endtask

    task automatic test_wrap;
        logic [5:0] ea [4] = '{6'd63, 6'd0, 6'd1, 6'd2};
        logic [7:0] ed [4] = '{8'h4E, 8'h4F, 8'h10, 8'h11};
        int nb = 0;
        out_ready = 1'b1;
        do_start(6'd62, 7'd4);
        capture(4'b1111, 20);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (tr_a[c] !== ea[c]) begin
                errors++;
                $display("FAIL wrap_addr%0d: addr=%0d want %0d", c, tr_a[c], ea[c]);
            end
        end
        for (int c = 0; c < tr_n; c++) begin
            if (tr_v[c] && tr_r[c]) begin
                checks++;
                if (nb > 3 || tr_d[c] !== ed[nb & 3]) begin
                    errors++;
                    $display("FAIL wrap_data%0d: data=%h want %h", nb, tr_d[c], ed[nb & 3]);
                end
                nb++;
            end
        end
        checks++;
        if (nb != 4 || tr_done[tr_n-1] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_count: beats=%0d done=%b want 4 1", nb, tr_done[tr_n-1]);
        end
    endtask

    task automatic test_backpressure;
        int nb = 0;
        logic [5:0] iss;
        out_ready = 1'b1;
        do_start(6'd30, 7'd8);
        capture(4'b1001, 100);
        for (int c = 0; c < tr_n; c++) begin
            if (c > 0 && tr_v[c-1] && !tr_r[c-1]) begin
                checks++;
                if (tr_v[c] !== 1'b1 || tr_d[c] !== tr_d[c-1]) begin
                    errors++;
                    $display("FAIL bp_stable%0d: v=%b data=%h want 1 %h", c, tr_v[c], tr_d[c], tr_d[c-1]);
                end
            end
            iss = tr_a[c] - 6'd30;
            checks++;
            if (int'(iss) - nb > 2) begin
                errors++;
                $display("FAIL bp_buffered%0d: outstanding=%0d want <=2", c, int'(iss) - nb);
            end
            if (tr_v[c] && tr_r[c]) begin
                checks++;
                if (tr_d[c] !== 8'(8'h2E + nb) || tr_l[c] !== (LAST_EN && nb == 7)) begin
                    errors++;
                    $display("FAIL bp_data%0d: data=%h last=%b want %h %b",
                             nb, tr_d[c], tr_l[c], 8'(8'h2E + nb), LAST_EN && nb == 7);
                end
                nb++;
            end
        end
        checks++;
        if (nb != 8 || tr_done[tr_n-1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_count: beats=%0d done=%b want 8 1", nb, tr_done[tr_n-1]);
        end
    endtask

    task automatic test_zero_len;
        do_start(6'd7, 7'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b v=%b want 1 0 0", done, busy, out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: done=%b v=%b busy=%b want 0 0 0", done, out_valid, busy);
        end
    endtask

    task automatic test_full_len;
        int nb = 0;
        out_ready = 1'b1;
        do_start(6'd0, 7'd64);
        capture(4'b1111, 100);
        for (int c = 0; c < tr_n; c++) begin
            if (tr_v[c] && tr_r[c]) begin
                checks++;
                if (tr_d[c] !== 8'(nb + 16) || tr_l[c] !== (LAST_EN && nb == 63)) begin
                    errors++;
                    $display("FAIL full_data%0d: data=%h last=%b want %h %b",
                             nb, tr_d[c], tr_l[c], 8'(nb + 16), LAST_EN && nb == 63);
                end
                nb++;
            end
        end
        checks++;
        if (nb != 64 || tr_n != 66 || tr_done[tr_n-1] !== 1'b1) begin
            errors++;
            $display("FAIL full_count: beats=%0d cycles=%0d done=%b want 64 66 1", nb, tr_n, tr_done[tr_n-1]);
        end
    endtask

    task automatic test_back_to_back;
        int nb = 0;
        out_ready = 1'b1;
        do_start(6'd0, 7'd2);
        capture(4'b1111, 20);
        // still on the cycle done is high
        start = 1'b1; base_addr = 6'd50; len = 7'd2;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || read_addr !== 6'd50) begin
            errors++;
            $display("FAIL b2b_start: busy=%b addr=%0d want 1 50", busy, read_addr);
        end
        capture(4'b1111, 20);
        for (int c = 0; c < tr_n; c++) begin
            if (tr_v[c] && tr_r[c]) begin
                checks++;
                if (tr_d[c] !== 8'(8'h42 + nb)) begin
                    errors++;
                    $display("FAIL b2b_data%0d: data=%h want %h", nb, tr_d[c], 8'(8'h42 + nb));
                end
                nb++;
            end
        end
        checks++;
        if (nb != 2 || tr_done[tr_n-1] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_count: beats=%0d done=%b want 2 1", nb, tr_done[tr_n-1]);
        end
    endtask

    task automatic test_busy_and_reset;
        int nb = 0;
        out_ready = 1'b1;
        do_start(6'd10, 7'd8);
        start = 1'b1; base_addr = 6'd40; len = 7'd2;  // ignored mid-burst
        @(negedge clk);
        start = 1'b0;
        capture(4'b1111, 40);
        for (int c = 0; c < tr_n; c++) begin
            if (tr_v[c] && tr_r[c]) begin
                checks++;
                if (tr_d[c] !== 8'(8'h1A + nb)) begin
                    errors++;
                    $display("FAIL busy_data%0d: data=%h want %h", nb, tr_d[c], 8'(8'h1A + nb));
                end
                nb++;
            end
        end
        @(negedge clk);
        checks++;
        if (nb != 8 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore: beats=%0d busy=%b v=%b want 8 0 0", nb, busy, out_valid);
        end

        // reset after the third beat is accepted
        nb = 0;
        do_start(6'd20, 7'd8);
        for (int c = 0; c < 30 && nb < 3; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) nb++;
        end
        checks++;
        if (nb != 3) begin
            errors++;
            $display("FAIL rst_mid_wait: beats=%0d want 3", nb);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, busy, done} !== 4'b0000 || read_addr !== 6'd0 || out_data !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid: v=%b l=%b busy=%b done=%b addr=%0d data=%h want all 0",
                     out_valid, out_last, busy, done, read_addr, out_data);
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_nodone%0d: done=%b v=%b want 0 0", c, done, out_valid);
            end
        end

        nb = 0;
        do_start(6'd3, 7'd3);
        capture(4'b1111, 20);
        for (int c = 0; c < tr_n; c++) begin
            if (tr_v[c] && tr_r[c]) begin
                checks++;
                if (tr_d[c] !== 8'(8'h13 + nb)) begin
                    errors++;
                    $display("FAIL rst_fresh%0d: data=%h want %h", nb, tr_d[c], 8'(8'h13 + nb));
                end
                nb++;
            end
        end
        checks++;
        if (nb != 3 || tr_done[tr_n-1] !== 1'b1) begin
            errors++;
            $display("FAIL rst_fresh_count: beats=%0d done=%b want 3 1", nb, tr_done[tr_n-1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_full_len();
        test_back_to_back();
        test_busy_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
